// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF       = 32;

  // Enable vector order: {pc, if_id, id_ex, ex_mem, mem_wb}
  localparam logic [4:0] EN_ALL      = 5'b11111;
  localparam logic [4:0] EN_LOAD_USE = 5'b00111;
  localparam logic [4:0] EN_NONE     = 5'b00000;

  // Flush vector order: {if_id, id_ex, ex_mem}
  localparam logic [2:0] FL_ALL      = 3'b111;
  localparam logic [2:0] FL_LOAD_USE = 3'b010;
  localparam logic [2:0] FL_NONE     = 3'b000;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources in ID.
module hazard_detect (
  input  logic       memread,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard = memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: load-use stalls, MEM-stage redirects, data-memory
// freeze with timeout, and saturating stall/flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             redirect_mem,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pc_sel_redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              load_use;
  logic              active;
  logic [4:0]        en_vec;
  logic [2:0]        fl_vec;
  logic              redirect;

  hazard_detect u_hazard_detect (
    .memread (id_ex_memread),
    .rd      (id_ex_rd),
    .rs1     (if_id_rs1),
    .rs2     (if_id_rs2),
    .hazard  (load_use)
  );

  assign wait_nxt = wait_cnt + WAIT_W'(1);

  // Outputs follow the registered state and live inputs; reset forces them low.
  always_comb begin
    active   = 1'b0;
    en_vec   = EN_NONE;
    fl_vec   = FL_NONE;
    redirect = 1'b0;
    if (!arst) begin
      case (state)
        RUN:      active = !(mem_access && !mem_ready);
        MEM_WAIT: active = mem_ready;
        default:  active = 1'b0;
      endcase
    end
    if (active) begin
      if (redirect_mem) begin
        en_vec   = EN_ALL;
        fl_vec   = FL_ALL;
        redirect = 1'b1;
      end else if (load_use) begin
        en_vec = EN_LOAD_USE;
        fl_vec = FL_LOAD_USE;
      end else begin
        en_vec = EN_ALL;
      end
    end
  end

  assign {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = en_vec;
  assign {flush_if_id, flush_id_ex, flush_ex_mem}          = fl_vec;
  assign pc_sel_redirect                                   = redirect;
  assign err                                               = (state == HALT);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_access && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            // wait_cnt counts frozen cycles including the current one.
            wait_cnt <= wait_nxt;
            if (wait_nxt >= WAIT_W'(MEM_TIMEOUT)) state <= HALT;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase

      if (!en_vec[4] && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] LU  = 5'b00111;
  localparam logic [4:0] NO  = 5'b00000;

  logic clk = 1'b0;
  logic arst;
  logic id_ex_memread;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic redirect_mem, mem_access, mem_ready;
  logic en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_redirect;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic err;

  typedef struct {
    string      name;
    logic [4:0] en;
    logic [2:0] fl;
    logic       ps;
    logic [3:0] sc;
    logic [3:0] fc;
    logic       er;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_miss = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .arst(arst),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .redirect_mem(redirect_mem), .mem_access(mem_access), .mem_ready(mem_ready),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
    .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .pc_sel_redirect(pc_sel_redirect),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic a, input logic mr, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic rm, input logic ma, input logic rdy);
    arst = a; id_ex_memread = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
    redirect_mem = rm; mem_access = ma; mem_ready = rdy;
  endtask

  task automatic expect_out(input string name, input logic [4:0] en, input logic [2:0] fl,
                            input logic ps, input int sc, input int fc, input logic er);
    exp_t e;
    e.name = name; e.en = en; e.fl = fl; e.ps = ps;
    e.sc = 4'(sc); e.fc = 4'(fc); e.er = er;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle on the falling edge.
  initial begin
    exp_t e;
    logic [4:0] a_en;
    logic [2:0] a_fl;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a_en = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb};
        a_fl = {flush_if_id, flush_id_ex, flush_ex_mem};
        n_vec++;
        if (a_en !== e.en || a_fl !== e.fl || pc_sel_redirect !== e.ps ||
            stall_cnt !== e.sc || flush_cnt !== e.fc || err !== e.er) begin
          n_miss++;
          $display("FAIL %s: got en=%b fl=%b ps=%b sc=%0d fc=%0d err=%b, want en=%b fl=%b ps=%b sc=%0d fc=%0d err=%b",
                   e.name, a_en, a_fl, pc_sel_redirect, stall_cnt, flush_cnt, err,
                   e.en, e.fl, e.ps, e.sc, e.fc, e.er);
        end
      end
    end
  end

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    expect_out("reset_hold", NO, 3'b000, 0, 0, 0, 0);

    drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("normal", ALL, 3'b000, 0, 0, 0, 0);
    drv(0, 1, 5, 3, 5, 0, 0, 0);  expect_out("load_use_rs2", LU, 3'b010, 0, 0, 0, 0);
    drv(0, 0, 0, 3, 5, 0, 0, 0);  expect_out("after_bubble", ALL, 3'b000, 0, 1, 0, 0);
    drv(0, 1, 9, 9, 0, 0, 0, 0);  expect_out("load_use_rs1", LU, 3'b010, 0, 1, 0, 0);
    drv(0, 1, 0, 0, 0, 0, 0, 0);  expect_out("rd_zero", ALL, 3'b000, 0, 2, 0, 0);
    drv(0, 1, 6, 7, 8, 0, 0, 0);  expect_out("no_match", ALL, 3'b000, 0, 2, 0, 0);
    drv(0, 1, 7, 7, 2, 1, 0, 0);  expect_out("redirect_over_hazard", ALL, 3'b111, 1, 2, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("after_redirect", ALL, 3'b000, 0, 2, 1, 0);
    drv(0, 0, 0, 0, 0, 1, 1, 1);  expect_out("redirect_mem_ready", ALL, 3'b111, 1, 2, 1, 0);

    drv(0, 0, 0, 0, 0, 1, 1, 0);  expect_out("freeze_over_redirect", NO, 3'b000, 0, 2, 2, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("wait_1", NO, 3'b000, 0, 3, 2, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("wait_2", NO, 3'b000, 0, 4, 2, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 1);  expect_out("wait_release", ALL, 3'b000, 0, 5, 2, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("after_wait", ALL, 3'b000, 0, 5, 2, 0);

    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("freeze_2", NO, 3'b000, 0, 5, 2, 0);
    drv(0, 0, 0, 0, 0, 1, 1, 1);  expect_out("wait_release_redirect", ALL, 3'b111, 1, 6, 2, 0);
    drv(0, 1, 4, 4, 0, 0, 0, 0);  expect_out("hazard_after_release", LU, 3'b010, 0, 6, 3, 0);

    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("to_1", NO, 3'b000, 0, 7, 3, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("to_2", NO, 3'b000, 0, 8, 3, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("to_3", NO, 3'b000, 0, 9, 3, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("to_4", NO, 3'b000, 0, 10, 3, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("halt_err", NO, 3'b000, 0, 11, 3, 1);
    drv(0, 0, 0, 0, 0, 1, 1, 1);  expect_out("halt_sticky", NO, 3'b000, 0, 12, 3, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);  expect_out("halt_13", NO, 3'b000, 0, 13, 3, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);  expect_out("halt_14", NO, 3'b000, 0, 14, 3, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);  expect_out("stall_sat", NO, 3'b000, 0, 15, 3, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);  expect_out("stall_sat_hold", NO, 3'b000, 0, 15, 3, 1);

    drv(1, 0, 0, 0, 0, 0, 0, 0);  expect_out("halt_reset", NO, 3'b000, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("run_after_halt", ALL, 3'b000, 0, 0, 0, 0);

    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("freeze_3", NO, 3'b000, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("wait3_1", NO, 3'b000, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0);  expect_out("wait3_2", NO, 3'b000, 0, 2, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 0);  expect_out("reset_mid_wait", NO, 3'b000, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("no_residual_freeze", ALL, 3'b000, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 1);  expect_out("access_ready", ALL, 3'b000, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      drv(0, 0, 0, 0, 0, 1, 0, 0);
      expect_out("flush_count", ALL, 3'b111, 1, 0, (i > 15) ? 15 : i, 0);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("flush_sat", ALL, 3'b000, 0, 0, 15, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, maximum data-memory wait cycles before error.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port arst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port id_ex_memread  input  1  load instruction in EX.
REQ-006 SHALL have port id_ex_rd  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port if_id_rs1  input  5  source register 1 of the instruction in ID.
REQ-008 SHALL have port if_id_rs2  input  5  source register 2 of the instruction in ID.
REQ-009 SHALL have port redirect_mem  input  1  taken branch or jump resolved in MEM.
REQ-010 SHALL have port mem_access  input  1  EX/MEM holds a load or store.
REQ-011 SHALL have port mem_ready  input  1  data memory completes the access this cycle.
REQ-012 SHALL have ports en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  output  1 each  pipeline register enables.
REQ-013 SHALL have ports flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  load bubble (zero control fields) on next edge.
REQ-014 SHALL have port pc_sel_redirect  output  1  PC loads redirect target.
REQ-015 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  performance counters.
REQ-016 SHALL have port err  output  1  sticky memory-timeout error.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, HALT; all outputs combinational from registered state plus current inputs; counters registered.
REQ-018 RUN, default: all enables 1, all flushes 0, pc_sel_redirect 0.
REQ-019 Load-use hazard = id_ex_memread & id_ex_rd!=0 & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2); in RUN: en_pc=0, en_if_id=0, flush_id_ex=1, others enabled; zero-cycle detection latency, one bubble per hazard.
REQ-020 Redirect in RUN (redirect_mem=1, mem_access=0 or mem_ready=1): pc_sel_redirect=1, flush_if_id=flush_id_ex=flush_ex_mem=1, all enables 1; overrides a simultaneous load-use hazard.
REQ-021 RUN with mem_access=1 and mem_ready=0: all enables 0, all flushes 0, pc_sel_redirect 0; next state MEM_WAIT; wait counter loads 1.
REQ-022 MEM_WAIT: all enables 0 while mem_ready=0; wait counter +1 per cycle; on mem_ready=1 outputs as RUN for that cycle (REQ-019/020 priority), next state RUN.
REQ-023 MEM_WAIT with wait counter reaching MEM_TIMEOUT and mem_ready=0: next state HALT, err=1 from that edge.
REQ-024 HALT: all enables 0, flushes 0, err=1; exits only by reset.
REQ-025 Priority: memory freeze > redirect > load-use > normal.
REQ-026 stall_cnt +1 every cycle en_pc=0; flush_cnt +1 every cycle pc_sel_redirect=1; both saturate at 2^CNT_W-1, no wrap.
REQ-027 id_ex_rd=0 SHALL never cause a stall.

Reset
REQ-028 arst=1 SHALL immediately force state RUN, wait counter 0, stall_cnt 0, flush_cnt 0, err 0.
REQ-029 While arst=1 all enables, flushes and pc_sel_redirect SHALL be 0; RUN behaviour starts first edge after deassertion.
REQ-030 Reset mid-MEM_WAIT or HALT SHALL abandon the wait with no residual freeze.

Structure
REQ-031 State encoding and MEM_TIMEOUT default SHALL live in shared package pipe_ctrl_pkg.
REQ-032 Load-use comparison SHALL be sub-module hazard_detect (combinational, 5-bit compares).

Verification
REQ-033 id_ex_memread=1, id_ex_rd=5, if_id_rs2=5 -> one cycle en_pc=0, en_if_id=0, flush_id_ex=1; stall_cnt 0->1.
REQ-034 id_ex_memread=1, id_ex_rd=0, if_id_rs1=0 -> no stall, all enables 1.
REQ-035 redirect_mem=1 with load-use on rd=7 -> pc_sel_redirect=1, three flushes 1, en_pc=1; flush_cnt 0->1.
REQ-036 mem_access=1, mem_ready low 3 cycles then high -> enables 0 for 3 cycles, 1 on 4th; stall_cnt +3.
REQ-037 mem_ready held 0, MEM_TIMEOUT=4 -> HALT, err=1 after 4 wait cycles, stays until arst pulse clears all to 0.
REQ-038 arst asserted mid-MEM_WAIT -> outputs 0 asynchronously, RUN with counters 0 after release.
